// File: rtl/ctl_round_if.sv
// ---------------------------------------------------------------------------
// ctl_round_if
// Groups the game-flow signals between the round sequencer (ctl_round) and
// the rest of the Duck Hunt datapath (trigger, duck, score and 7-seg mux).
//
// Signals (direction as seen by ctl_round, the slave modport):
//   i_start          in   level, start button
//   i_new_frame      in   1-cycle pulse per VGA frame
//   i_shot_fired     in   1-cycle pulse per trigger pull
//   i_hit            in   1-cycle pulse, shot hit the duck
//   i_duck_gone      in   level, duck left screen / fall finished
//   o_duck_spawn     out  1-cycle pulse, start a new duck
//   o_duck_escape    out  level, duck must fly away
//   o_score_reset    out  1-cycle pulse at game start
//   o_ammo           out  [3:0] remaining shots
//   o_hits_in_round  out  [3:0] hits in current round
//   o_duck_idx       out  [3:0] ducks spawned in current round
//   o_round_num      out  [7:0] current round
//   o_game_over      out  level, high in GAME_OVER
//   o_speed_lvl      out  [2:0] duck speed level
//
// The master modport belongs to whatever drives the sequencer's inputs
// (the surrounding datapath, or a testbench).
// ---------------------------------------------------------------------------
interface ctl_round_if;
  logic       i_start;
  logic       i_new_frame;
  logic       i_shot_fired;
  logic       i_hit;
  logic       i_duck_gone;
  logic       o_duck_spawn;
  logic       o_duck_escape;
  logic       o_score_reset;
  logic [3:0] o_ammo;
  logic [3:0] o_hits_in_round;
  logic [3:0] o_duck_idx;
  logic [7:0] o_round_num;
  logic       o_game_over;
  logic [2:0] o_speed_lvl;

  modport master (
    output i_start, i_new_frame, i_shot_fired, i_hit, i_duck_gone,
    input  o_duck_spawn, o_duck_escape, o_score_reset, o_ammo,
           o_hits_in_round, o_duck_idx, o_round_num, o_game_over, o_speed_lvl
  );

  modport slave (
    input  i_start, i_new_frame, i_shot_fired, i_hit, i_duck_gone,
    output o_duck_spawn, o_duck_escape, o_score_reset, o_ammo,
           o_hits_in_round, o_duck_idx, o_round_num, o_game_over, o_speed_lvl
  );
endinterface

// File: rtl/ctl_round.sv
// ---------------------------------------------------------------------------
// ctl_round
// Game-flow sequencer for Duck Hunt. Owns ammo, ducks per round, the fly-away
// timeout and round/game-over decisions; issues duck spawn, escape and score
// reset commands, and supplies live ammo/round values to the 7-seg mux.
//
// Ports:
//   clk   in  system clock (65 MHz)
//   rst   in  asynchronous, active-low reset
//   bus   ctl_round_if.slave, see rtl/ctl_round_if.sv for the signal list
//
// Optional feature: define DH_ROUND_SPEEDUP_EN to drive o_speed_lvl with
// min(round_num-1, 7); when undefined o_speed_lvl is tied to 0.
//
// All outputs are registered; o_duck_spawn and o_score_reset are single
// clock pulses.
// ---------------------------------------------------------------------------
module ctl_round #(
  parameter int unsigned AMMO_PER_DUCK   = 3,
  parameter int unsigned DUCKS_PER_ROUND = 10,
  parameter int unsigned HITS_TO_PASS    = 6,
  parameter int unsigned FLY_FRAMES      = 300,
  parameter int unsigned PAUSE_FRAMES    = 60
) (
  input  logic       clk,
  input  logic       rst,
  ctl_round_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPAWN,
    S_FLYING,
    S_ESCAPE,
    S_PAUSE,
    S_ROUND_END,
    S_GAME_OVER
  } state_t;

  // One frame counter serves both the fly timeout and the pause, so it is
  // sized for the longer of the two.
  localparam int unsigned CTR_MAX = (FLY_FRAMES > PAUSE_FRAMES) ? FLY_FRAMES : PAUSE_FRAMES;
  localparam int unsigned CTR_W   = $clog2(CTR_MAX + 1);
  localparam logic [CTR_W-1:0] FLY_LAST   = CTR_W'(FLY_FRAMES - 1);
  localparam logic [CTR_W-1:0] PAUSE_LAST = CTR_W'(PAUSE_FRAMES - 1);

  state_t           r_state;
  logic [CTR_W-1:0] r_frame_ctr;
  logic             r_start_d;
  logic             r_duck_spawn;
  logic             r_duck_escape;
  logic             r_score_reset;
  logic [3:0]       r_ammo;
  logic [3:0]       r_hits_in_round;
  logic [3:0]       r_duck_idx;
  logic [7:0]       r_round_num;
  logic             r_game_over;

  logic w_start_game;
  logic w_shot_ok;
  logic w_pass;

  // Start is a level; only a fresh press counts, so a held button never
  // restarts a finished game.
  assign w_start_game = ((r_state == S_IDLE) || (r_state == S_GAME_OVER)) &&
                        bus.i_start && !r_start_d;
  // Shots with an empty magazine are dropped, so ammo never wraps.
  assign w_shot_ok    = bus.i_shot_fired && (r_ammo != 4'd0);
  assign w_pass       = (r_hits_in_round >= 4'(HITS_TO_PASS));

  // NOTE: every register, pulses included, is cleared by the async reset so
  // a reset mid-game drops any pending pulse and lands cleanly in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= S_IDLE;
      r_frame_ctr     <= '0;
      r_start_d       <= 1'b0;
      r_duck_spawn    <= 1'b0;
      r_duck_escape   <= 1'b0;
      r_score_reset   <= 1'b0;
      r_ammo          <= 4'd0;
      r_hits_in_round <= 4'd0;
      r_duck_idx      <= 4'd0;
      r_round_num     <= 8'd0;
      r_game_over     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; the defaults below are
      // overridden by later assignments in the same cycle, which is what
      // makes the spawn/reset outputs exactly one clock wide.
      r_start_d     <= bus.i_start;
      r_duck_spawn  <= 1'b0;
      r_score_reset <= 1'b0;

      case (r_state)
        S_IDLE, S_GAME_OVER: begin
          if (w_start_game) begin
            r_score_reset   <= 1'b1;
            r_round_num     <= 8'd1;
            r_hits_in_round <= 4'd0;
            r_duck_idx      <= 4'd0;
            r_game_over     <= 1'b0;
            r_state         <= S_SPAWN;
          end
        end

        S_SPAWN: begin
          r_duck_spawn <= 1'b1;
          r_ammo       <= 4'(AMMO_PER_DUCK);
          r_duck_idx   <= r_duck_idx + 4'd1;
          r_frame_ctr  <= '0;
          r_state      <= S_FLYING;
        end

        S_FLYING: begin
          if (w_shot_ok) r_ammo <= r_ammo - 4'd1;
          // A hit outranks running out of ammo or time in the same cycle;
          // the shot that scored it still consumes a round.
          if (bus.i_hit) begin
            r_hits_in_round <= r_hits_in_round + 4'd1;
            r_frame_ctr     <= '0;
            r_state         <= S_PAUSE;
          end else if (w_shot_ok && (r_ammo == 4'd1)) begin
            r_duck_escape <= 1'b1;
            r_state       <= S_ESCAPE;
          end else if (bus.i_new_frame) begin
            if (r_frame_ctr == FLY_LAST) begin
              r_duck_escape <= 1'b1;
              r_state       <= S_ESCAPE;
            end else begin
              r_frame_ctr <= r_frame_ctr + 1'b1;
            end
          end
        end

        S_ESCAPE: begin
          if (bus.i_duck_gone) begin
            r_duck_escape <= 1'b0;
            r_frame_ctr   <= '0;
            r_state       <= S_PAUSE;
          end
        end

        S_PAUSE: begin
          if (bus.i_new_frame) begin
            if (r_frame_ctr == PAUSE_LAST) begin
              r_frame_ctr <= '0;
              r_state     <= (r_duck_idx < 4'(DUCKS_PER_ROUND)) ? S_SPAWN : S_ROUND_END;
            end else begin
              r_frame_ctr <= r_frame_ctr + 1'b1;
            end
          end
        end

        S_ROUND_END: begin
          if (w_pass) begin
            r_round_num     <= (r_round_num == 8'hFF) ? r_round_num : r_round_num + 8'd1;
            r_hits_in_round <= 4'd0;
            r_duck_idx      <= 4'd0;
            r_state         <= S_SPAWN;
          end else begin
            // Ammo, hits and round are left untouched for the display.
            r_game_over <= 1'b1;
            r_state     <= S_GAME_OVER;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_duck_spawn    = r_duck_spawn;
  assign bus.o_duck_escape   = r_duck_escape;
  assign bus.o_score_reset   = r_score_reset;
  assign bus.o_ammo          = r_ammo;
  assign bus.o_hits_in_round = r_hits_in_round;
  assign bus.o_duck_idx      = r_duck_idx;
  assign bus.o_round_num     = r_round_num;
  assign bus.o_game_over     = r_game_over;

`ifdef DH_ROUND_SPEEDUP_EN
  logic [2:0] r_speed_lvl;

  // On advance the new round is r_round_num+1, so the level is the old
  // round number clamped to 7.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_speed_lvl <= 3'd0;
    end else if (w_start_game) begin
      r_speed_lvl <= 3'd0;
    end else if ((r_state == S_ROUND_END) && w_pass) begin
      r_speed_lvl <= (r_round_num >= 8'd7) ? 3'd7 : r_round_num[2:0];
    end
  end

  assign bus.o_speed_lvl = r_speed_lvl;
`else
  assign bus.o_speed_lvl = 3'd0;
`endif

endmodule
